argmin_pipe: RTL and testbench
==============================

Name: argmin_pipe

Overview:
- Generic pipelined argmin over NUM_INP unsigned costs per beat.
- Successor to the fixed-size argmin trees. Adds:
  - arbitrary input count;
  - a valid/ready stream with backpressure;
  - a deterministic tie-break;
  - optional second-best tracking for a uniqueness (confidence) check.
- Sits between the census Hamming-cost array and disparity output/post-filtering.

Parameters:
- WIDTH, 8, bit width of each cost.
- NUM_INP, 64, number of costs per beat; legal range 2..256.
- UNIQ_MARGIN, 4, minimum gap (second − best) for a result to be declared unique.
- ADDR_WIDTH, $clog2(NUM_INP), width of index output. Derived; not to be overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  inp holds a valid cost vector.
- in_ready  output  1  pipeline accepts a beat this cycle.
- inp  input  WIDTH*NUM_INP  costs; element i at bits [WIDTH*i +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- outp  output  WIDTH  minimum cost.
- outp_addr  output  ADDR_WIDTH  index of minimum.
- outp_second  output  WIDTH  second-smallest cost, excluding the winning element.
- outp_unique  output  1  uniqueness flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All valid bits clear; out_valid=0.
  - outp, outp_addr and outp_second reset to 0; outp_unique resets to 0.
  - Data registers may also clear.
- Reset mid-operation: every in-flight beat is discarded. No beat may emerge after reset deasserts unless it was accepted after deassertion.
- Tree structure: LEVELS = $clog2(NUM_INP) register stages.
  - Stage k reduces N_k elements to ceil(N_k/2).
  - With odd N_k, the last element passes through registered, unchanged with its address.
- Node compare: pair (a, b) with a the lower index.
  - Winner = a if a.cost <= b.cost, else b. Ties go to the lowest index.
  - Address travels with cost; level-0 addresses are the constant element index.
- Latency: an accepted beat appears at out_valid exactly LEVELS cycles later, provided no stall occurs.
  - NUM_INP=80 → 7.
  - NUM_INP=2 → 1.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - On advance, every stage captures the previous stage, and the valid bits shift with the data.
  - When advance=0, all stages hold; nothing is lost or duplicated.
  - A beat is accepted on in_valid && in_ready.
  - Bubbles (in_valid=0 while advancing) propagate as invalid stages.
  - out_valid, outp and the other outputs stay stable while out_valid && !out_ready.
- Simultaneous output handshake and new input acceptance in one cycle is required; sustained throughput is 1 beat/cycle.
- Costs are unsigned. No arithmetic widening is needed for compares.

Optional Feature:
- Macro: ARGMIN_PIPE_SECOND_EN.
- Defined:
  - Each node also carries min2.
    - new_min1 = winner.min1.
    - new_min2 = min(winner.min2, loser.min1).
    - Pass-through elements keep their min2. Level-0 min2 = all-ones.
  - outp_second = final min2.
  - outp_unique = 1 when (second − best) >= UNIQ_MARGIN, computed in WIDTH+1 bits. It can never underflow, since second >= best.
- Undefined:
  - No min2 registers.
  - outp_second is tied to all-ones and outp_unique is tied to 1.

Test Plan:
- Unique min: NUM_INP=80, WIDTH=8, all costs 50, cost[37]=3.
  - Response: 7 cycles later, outp=3, outp_addr=37.
  - With SECOND_EN: outp_second=50, outp_unique=1.
- Tie-break: costs all 9 except cost[12]=cost[70]=2.
  - Response: outp=2, outp_addr=12.
  - With SECOND_EN: outp_second=2, outp_unique=0.
- Odd width / edge index: NUM_INP=5, costs {7,7,7,7,1}.
  - Response: outp_addr=4, latency 3.
  - Also run NUM_INP=2 with {0,255}: addr 0, latency 1.
- Backpressure: stream 20 beats with distinct argmin indices 0..19, toggling out_ready in a 1-on/2-off pattern.
  - Response: all 20 outputs in order, none dropped or duplicated, outputs stable while stalled.
  - in_ready follows out_ready whenever out_valid=1.
- Margin boundary: UNIQ_MARGIN=4, best=10, second=14.
  - Response: outp_unique=1.
  - Second=13 gives 0.
- Reset mid-stream: assert rst asynchronously (between edges) with 5 beats in flight.
  - Response: out_valid drops immediately, then stays 0 until the first new beat.

Source files
------------

// File: rtl/argmin_pipe.sv
// Pipelined argmin tree over NUM_INP unsigned costs with a valid/ready stream and lowest-index tie-break.
// Optional feature macro: ARGMIN_PIPE_SECOND_EN adds runner-up tracking and the uniqueness flag.
module argmin_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_INP     = 64,
    parameter int unsigned UNIQ_MARGIN = 4,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_INP)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*NUM_INP-1:0] inp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         outp,
    output logic [ADDR_WIDTH-1:0]    outp_addr,
    output logic [WIDTH-1:0]         outp_second,
    output logic                     outp_unique
);

    localparam int unsigned LEVELS = $clog2(NUM_INP);

    // Element count of tree level k (level 0 is the raw input vector).
    function automatic int unsigned level_size(input int unsigned k);
        int unsigned n = NUM_INP;
        for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Offset of level k within the flattened node arrays.
    function automatic int unsigned level_base(input int unsigned k);
        int unsigned b = 0;
        for (int unsigned i = 0; i < k; i++) b += level_size(i);
        return b;
    endfunction

    localparam int unsigned TOTAL = level_base(LEVELS + 1);

    if (NUM_INP < 2 || NUM_INP > 256 || UNIQ_MARGIN >= (1 << (WIDTH + 1))) begin : g_bad_param
        $error("argmin_pipe: illegal parameter value");
    end

    logic              advance;
    logic [LEVELS-1:0] stage_valid;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stage_valid[LEVELS-1];

    // Valid bits shift alongside the data; a bubble is simply a cleared bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (advance) begin
            stage_valid[0] <= in_valid;
            for (int k = 1; k < LEVELS; k++) stage_valid[k] <= stage_valid[k-1];
        end
    end

    logic [WIDTH-1:0]      node_cost [TOTAL];
    logic [ADDR_WIDTH-1:0] node_addr [TOTAL];
`ifdef ARGMIN_PIPE_SECOND_EN
    logic [WIDTH-1:0]      node_min2 [TOTAL];
`endif

    for (genvar i = 0; i < NUM_INP; i++) begin : g_src
        assign node_cost[i] = inp[WIDTH*i +: WIDTH];
        assign node_addr[i] = ADDR_WIDTH'(i);
`ifdef ARGMIN_PIPE_SECOND_EN
        assign node_min2[i] = '1;
`endif
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int unsigned NI = level_size(k);
        localparam int unsigned NO = level_size(k + 1);
        localparam int unsigned BI = level_base(k);
        localparam int unsigned BO = level_base(k + 1);

        for (genvar j = 0; j < NO; j++) begin : g_node
            localparam int unsigned A = BI + 2 * j;

            logic [WIDTH-1:0]      d_cost, q_cost;
            logic [ADDR_WIDTH-1:0] d_addr, q_addr;
`ifdef ARGMIN_PIPE_SECOND_EN
            logic [WIDTH-1:0]      d_min2, q_min2;
`endif

            if (2 * j + 1 < NI) begin : g_pair
                // Lower index wins ties, so the comparison is non-strict in its favour.
                logic a_wins;
                assign a_wins = node_cost[A] <= node_cost[A+1];
                assign d_cost = a_wins ? node_cost[A] : node_cost[A+1];
                assign d_addr = a_wins ? node_addr[A] : node_addr[A+1];
`ifdef ARGMIN_PIPE_SECOND_EN
                logic [WIDTH-1:0] win_min2, lose_min1;
                assign win_min2  = a_wins ? node_min2[A] : node_min2[A+1];
                assign lose_min1 = a_wins ? node_cost[A+1] : node_cost[A];
                assign d_min2    = (lose_min1 < win_min2) ? lose_min1 : win_min2;
`endif
            end else begin : g_pass
                assign d_cost = node_cost[A];
                assign d_addr = node_addr[A];
`ifdef ARGMIN_PIPE_SECOND_EN
                assign d_min2 = node_min2[A];
`endif
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_cost <= '0;
                    q_addr <= '0;
`ifdef ARGMIN_PIPE_SECOND_EN
                    q_min2 <= '0;
`endif
                end else if (advance) begin
                    q_cost <= d_cost;
                    q_addr <= d_addr;
`ifdef ARGMIN_PIPE_SECOND_EN
                    q_min2 <= d_min2;
`endif
                end
            end

            assign node_cost[BO+j] = q_cost;
            assign node_addr[BO+j] = q_addr;
`ifdef ARGMIN_PIPE_SECOND_EN
            assign node_min2[BO+j] = q_min2;
`endif
        end
    end

    assign outp      = node_cost[TOTAL-1];
    assign outp_addr = node_addr[TOTAL-1];

`ifdef ARGMIN_PIPE_SECOND_EN
    localparam logic [WIDTH:0] MARGIN = (WIDTH + 1)'(UNIQ_MARGIN);

    // second >= best always holds, so the widened difference never wraps.
    logic [WIDTH:0] gap;
    assign outp_second = node_min2[TOTAL-1];
    assign gap         = {1'b0, outp_second} - {1'b0, outp};
    assign outp_unique = out_valid && (gap >= MARGIN);
`else
    assign outp_second = '1;
    assign outp_unique = 1'b1;
`endif

endmodule

// File: tb/tb_argmin_pipe.sv
// Scoreboard bench for argmin_pipe: three instances (80, 5 and 2 inputs) driven with directed vectors.
module tb_argmin_pipe;

    localparam int unsigned W = 8;
`ifdef ARGMIN_PIPE_SECOND_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif

    typedef struct {
        int cost;
        int addr;
        int second;
        int uniq;
        int acc;
        bit chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            a_iv, a_ir, a_ov, a_or, a_uq;
    logic [80*W-1:0] a_inp;
    logic [W-1:0]    a_o, a_s;
    logic [6:0]      a_ad;

    logic            b_iv, b_ir, b_ov, b_or, b_uq;
    logic [5*W-1:0]  b_inp;
    logic [W-1:0]    b_o, b_s;
    logic [2:0]      b_ad;

    logic            c_iv, c_ir, c_ov, c_or, c_uq;
    logic [2*W-1:0]  c_inp;
    logic [W-1:0]    c_o, c_s;
    logic [0:0]      c_ad;

    argmin_pipe #(.WIDTH(W), .NUM_INP(80), .UNIQ_MARGIN(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .inp(a_inp),
        .out_valid(a_ov), .out_ready(a_or), .outp(a_o), .outp_addr(a_ad),
        .outp_second(a_s), .outp_unique(a_uq)
    );

    argmin_pipe #(.WIDTH(W), .NUM_INP(5), .UNIQ_MARGIN(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .inp(b_inp),
        .out_valid(b_ov), .out_ready(b_or), .outp(b_o), .outp_addr(b_ad),
        .outp_second(b_s), .outp_unique(b_uq)
    );

    argmin_pipe #(.WIDTH(W), .NUM_INP(2), .UNIQ_MARGIN(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .inp(c_inp),
        .out_valid(c_ov), .out_ready(c_or), .outp(c_o), .outp_addr(c_ad),
        .outp_second(c_s), .outp_unique(c_uq)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q [3][$];
    int   lat [3] = '{7, 3, 1};
    bit   was_vis [3];
    int   vis_since [3];
    int   hold_o [3], hold_a [3], hold_s [3], hold_u [3];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int c, input int a, input int s, input int u);
        exp_t e;
        e.cost    = c;
        e.addr    = a;
        e.second  = SEC_EN ? s : 255;
        e.uniq    = SEC_EN ? u : 1;
        e.acc     = 0;
        e.chk_lat = 1'b1;
        return e;
    endfunction

    function automatic bit get_ir(input int d);
        return (d == 0) ? a_ir : (d == 1) ? b_ir : c_ir;
    endfunction

    // Monitor: checks handshake, stall stability, and pops the scoreboard on each transfer.
    task automatic mon(input int d, input bit ov, input bit orr, input bit ir,
                       input int o, input int a, input int s, input int u);
        exp_t e;
        if (rst) begin
            was_vis[d] = 1'b0;
            return;
        end
        chk("in_ready", d, int'(ir), int'(!ov || orr));
        if (!ov) return;
        if (!was_vis[d]) begin
            was_vis[d]   = 1'b1;
            vis_since[d] = cyc;
            hold_o[d] = o; hold_a[d] = a; hold_s[d] = s; hold_u[d] = u;
        end else begin
            chk("stall_outp", d, o, hold_o[d]);
            chk("stall_addr", d, a, hold_a[d]);
            chk("stall_second", d, s, hold_s[d]);
            chk("stall_unique", d, u, hold_u[d]);
        end
        if (orr) begin
            was_vis[d] = 1'b0;
            if (q[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out dut%0d: got outp=%0d addr=%0d with nothing expected", d, o, a);
            end else begin
                e = q[d].pop_front();
                chk("outp", d, o, e.cost);
                chk("outp_addr", d, a, e.addr);
                chk("outp_second", d, s, e.second);
                chk("outp_unique", d, u, e.uniq);
                if (e.chk_lat) chk("latency", d, vis_since[d] - e.acc, lat[d]);
            end
        end
    endtask

    always @(negedge clk) mon(0, a_ov, a_or, a_ir, int'(a_o), int'(a_ad), int'(a_s), int'(a_uq));
    always @(negedge clk) mon(1, b_ov, b_or, b_ir, int'(b_o), int'(b_ad), int'(b_s), int'(b_uq));
    always @(negedge clk) mon(2, c_ov, c_or, c_ir, int'(c_o), int'(c_ad), int'(c_s), int'(c_uq));

    // Present one beat on dut d (data already set) and push its expectation on acceptance.
    task automatic send(input int d, input exp_t e);
        int budget = 0;
        case (d)
            0: a_iv = 1'b1;
            1: b_iv = 1'b1;
            default: c_iv = 1'b1;
        endcase
        @(negedge clk);
        while (!get_ir(d) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            chk("accept_timeout", d, 0, 1);
        end else begin
            e.acc = cyc;
            q[d].push_back(e);
        end
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        b_iv = 1'b0;
        c_iv = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 9, q[0].size() + q[1].size() + q[2].size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst  = 1'b1;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        a_inp = '0;  b_inp = '0;  c_inp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, int'(a_ov), 0);
        chk("rst_outp", 0, int'(a_o), 0);
        chk("rst_addr", 0, int'(a_ad), 0);
        chk("rst_second", 0, int'(a_s), SEC_EN ? 0 : 255);
        chk("rst_unique", 0, int'(a_uq), SEC_EN ? 0 : 1);
        chk("rst_valid", 1, int'(b_ov), 0);
        chk("rst_valid", 2, int'(c_ov), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wide instance: unique min, tie, margin boundary, last index.
        a_inp = {80{8'd50}};  a_inp[37*8 +: 8] = 8'd3;
        send(0, mk(3, 37, 50, 1));
        a_inp = {80{8'd9}};   a_inp[12*8 +: 8] = 8'd2;  a_inp[70*8 +: 8] = 8'd2;
        send(0, mk(2, 12, 2, 0));
        a_inp = {80{8'd200}}; a_inp[5*8 +: 8] = 8'd10;  a_inp[60*8 +: 8] = 8'd14;
        send(0, mk(10, 5, 14, 1));
        a_inp[60*8 +: 8] = 8'd13;
        send(0, mk(10, 5, 13, 0));
        a_inp = {80{8'd255}}; a_inp[79*8 +: 8] = 8'd0;
        send(0, mk(0, 79, 255, 1));

        // Five-input instance exercises the odd pass-through path.
        b_inp = {8'd1, 8'd7, 8'd7, 8'd7, 8'd7};
        send(1, mk(1, 4, 7, 1));
        b_inp = {8'd9, 8'd9, 8'd3, 8'd9, 8'd3};
        send(1, mk(3, 0, 3, 0));
        b_inp = {8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(1, mk(5, 4, 6, 0));
        b_inp = {8'd4, 8'd9, 8'd9, 8'd9, 8'd4};
        send(1, mk(4, 0, 4, 0));

        // Two-input instance: single stage.
        c_inp = {8'd255, 8'd0};
        send(2, mk(0, 0, 255, 1));
        c_inp = {8'd5, 8'd5};
        send(2, mk(5, 0, 5, 0));
        c_inp = {8'd100, 8'd200};
        send(2, mk(100, 1, 200, 1));
        wait_drain("drain_directed");

        // Backpressure: 20 beats while out_ready runs 1-on/2-off.
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    a_inp = {80{8'd100}};
                    a_inp[n*8 +: 8] = 8'(n);
                    e = mk(n, n, 100, 1);
                    e.chk_lat = 1'b0;
                    send(0, e);
                end
            end
            begin
                for (int t = 0; t < 90; t++) begin
                    a_or = (t % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                a_or = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // Reset with five beats in flight and the head stalled at the output.
        a_or = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a_inp = {80{8'd60}};
            a_inp[(n+10)*8 +: 8] = 8'(n);
            send(0, mk(n, n + 10, 60, 1));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_valid", 0, int'(a_ov), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 0, int'(a_ov), 0);
        q[0].delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        a_or = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("post_rst_idle", 0, int'(a_ov), 0);
        end
        @(posedge clk);
        #1;
        a_inp = {80{8'd60}};
        a_inp[3*8 +: 8] = 8'd1;
        send(0, mk(1, 3, 60, 1));
        wait_drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
